subleq_dual_port_mem: RTL

//   Responder end of the processor's dual-port memory interface. Holds the

---
 rtl/subleq_dual_port_mem_if.sv | 43 ++++
 rtl/subleq_dual_port_mem.sv | 106 ++++++++++
 2 files changed

// File: rtl/subleq_dual_port_mem_if.sv
// Shared word-size package and the processor/memory bus bundle
// for the subleq dual-port memory.
package gc;
   parameter int WORD_SIZE = 16;
endpackage

interface subleq_dual_port_mem_if #(
   parameter int WORD_SIZE = gc::WORD_SIZE
);
   logic [WORD_SIZE-1:0] add1;
   logic [WORD_SIZE-1:0] data_in1;
   logic                 write1;
   logic [WORD_SIZE-1:0] data_out1;
   logic [WORD_SIZE-1:0] add2;
   logic [WORD_SIZE-1:0] data_in2;
   logic                 write2;
   logic [WORD_SIZE-1:0] data_out2;
   logic                 ld_valid;
   logic [WORD_SIZE-1:0] ld_data;
   logic                 ld_last;
   logic                 ld_ready;
   logic                 mem_ready;
   logic [WORD_SIZE-1:0] io_out;
   logic                 collision;

   modport master (
      output add1, data_in1, write1,
      output add2, data_in2, write2,
      output ld_valid, ld_data, ld_last,
      input  data_out1, data_out2,
      input  ld_ready, mem_ready,
      input  io_out, collision
   );

   modport slave (
      input  add1, data_in1, write1,
      input  add2, data_in2, write2,
      input  ld_valid, ld_data, ld_last,
      output data_out1, data_out2,
      output ld_ready, mem_ready,
      output io_out, collision
   );
endinterface

// File: rtl/subleq_dual_port_mem.sv
// Dual-port subleq memory: zero-fill, streamed program load,
// then read-first two-port access with an MMIO output register.
module subleq_dual_port_mem #(
   parameter int WORD_SIZE = gc::WORD_SIZE,
   parameter int ADDR_BITS = 8,
   parameter int MMIO_ADDR = 2**ADDR_BITS-1
) (
   input logic                   clk,
   input logic                   rst_n,
   subleq_dual_port_mem_if.slave bus
);
   localparam int DEPTH = 2**ADDR_BITS;

   typedef logic [ADDR_BITS-1:0] addr_t;
   typedef logic [WORD_SIZE-1:0] word_t;

   localparam addr_t LAST = addr_t'(DEPTH-1);
   localparam addr_t MMIO = addr_t'(MMIO_ADDR);

   typedef enum logic [1:0] {
      CLEAR,
      LOAD,
      RUN
   } state_t;

   state_t state;
   addr_t  ptr;
   word_t  mem [DEPTH];

   addr_t a1;
   addr_t a2;
   logic  run;
   logic  ld_hs;
   logic  ld_end;
   logic  we1;
   logic  we2;
   logic  unused_hi;

   assign a1     = bus.add1[ADDR_BITS-1:0];
   assign a2     = bus.add2[ADDR_BITS-1:0];
   assign run    = (state == RUN);
   assign ld_hs  = (state == LOAD) && bus.ld_valid;
   assign ld_end = bus.ld_last || (ptr == LAST);
   assign we1    = run && bus.write1;
   assign we2    = run && bus.write2;

   // Upper address bits alias onto the low ones by design.
   assign unused_hi = ^{bus.add1[WORD_SIZE-1:ADDR_BITS],
                        bus.add2[WORD_SIZE-1:ADDR_BITS]};

   assign bus.ld_ready  = (state == LOAD);
   assign bus.mem_ready = run;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         unique case (state)
            CLEAR: begin
               ptr <= ptr + addr_t'(1);
               if (ptr == LAST)
                  state <= LOAD;
            end
            LOAD: begin
               if (bus.ld_valid) begin
                  ptr <= ld_end ? '0 : ptr + addr_t'(1);
                  if (ld_end)
                     state <= RUN;
               end
            end
            RUN: ;
            default: state <= CLEAR;
         endcase
      end
   end

   // Port 1 is written last so it wins a same-address clash.
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         mem[ptr] <= '0;
      else if (ld_hs)
         mem[ptr] <= bus.ld_data;
      if (we2)
         mem[a2] <= bus.data_in2;
      if (we1)
         mem[a1] <= bus.data_in1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.data_out1 <= '0;
         bus.data_out2 <= '0;
         bus.io_out    <= '0;
         bus.collision <= 1'b0;
      end else begin
         bus.data_out1 <= run ? mem[a1] : '0;
         bus.data_out2 <= run ? mem[a2] : '0;
         bus.collision <= we1 && we2 && (a1 == a2);
         if (we1 && (a1 == MMIO))
            bus.io_out <= bus.data_in1;
         else if (we2 && (a2 == MMIO))
            bus.io_out <= bus.data_in2;
      end
   end
endmodule
